// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the memory stage: word type, stage FSM states
// and the byte-offset width ignored by the word-address compares.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2
  } memstate_t;

  localparam int WBYTE_OFF = 2;

endpackage

// File: rtl/mem_stage_if.sv
// Data-cache port of the memory stage: request side driven by the stage
// (master), completion/read data and coherence snoop driven by the cache
// (slave).
interface mem_stage_if #(
  parameter int WORD_W = 32
);
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              dhit;
  logic [WORD_W-1:0] dload;
  logic              ccinv;
  logic [WORD_W-1:0] ccaddr;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dload, ccinv, ccaddr
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dload, ccinv, ccaddr
  );
endinterface

// File: rtl/link_reg.sv
// Load-linked / store-conditional link register. Holds the word address of
// the last completed LL, compares it against SC addresses and coherence
// invalidates (byte offset ignored), and reports whether the SC fails.
// An invalidate matching an LL completing in the same cycle wins.
module link_reg
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ll_hit,    // LL completing this cycle
  input  logic              sc_issue,  // SC presented to the cache this cycle
  input  logic              SC_in,
  input  logic              dhit,
  input  logic [WORD_W-1:0] addr_in,
  input  logic              ccinv,
  input  logic [WORD_W-1:0] ccaddr,
  output logic              sc_fail
);

  localparam int AW = WORD_W - WBYTE_OFF;

  logic          link_valid_q, link_valid_d;
  logic [AW-1:0] link_addr_q, link_addr_d;
  logic          match_s, inv_old_s, inv_new_s, sc_done_s;
  logic          unused_s;

  assign unused_s = ^{addr_in[WBYTE_OFF-1:0], ccaddr[WBYTE_OFF-1:0]};

  // Address compares, SC outcome and SC completion (a failed SC completes at once)
  always_comb begin
    match_s   = link_valid_q & (link_addr_q == addr_in[WORD_W-1:WBYTE_OFF]);
    inv_old_s = ccinv & (ccaddr[WORD_W-1:WBYTE_OFF] == link_addr_q);
    inv_new_s = ccinv & (ccaddr[WORD_W-1:WBYTE_OFF] == addr_in[WORD_W-1:WBYTE_OFF]);
    sc_fail   = SC_in & ~match_s;
    sc_done_s = sc_issue & (sc_fail | dhit);
  end

  // Next link state: LL sets (unless invalidated in the same cycle), SC or snoop clears
  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (ll_hit) begin
      link_addr_d  = addr_in[WORD_W-1:WBYTE_OFF];
      link_valid_d = ~inv_new_s;
    end else if (sc_done_s | inv_old_s) begin
      link_valid_d = 1'b0;
    end else begin
      link_valid_d = link_valid_q;
    end
  end

  // Link register flops
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the data-cache request, stalls the pipeline on
// a miss, holds the returned word while a downstream hazard freezes the
// pipeline, and gates the register-write qualifier.
// Optional feature macro LLSC_EN: when defined, LL/SC use the link register
// (link_reg); otherwise LL is a plain load and SC an unconditional store
// returning 1.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              memREN_in,
  input  logic              memWEN_in,
  input  logic              LL_in,
  input  logic              SC_in,
  input  logic [WORD_W-1:0] addr_in,
  input  logic [WORD_W-1:0] store_in,
  input  logic              regWEN_in,
  input  logic              pipe_stall,
  mem_stage_if.master       bus,
  output logic              mem_stall,
  output logic [WORD_W-1:0] dmemload_out,
  output logic              regWEN_out
);

  memstate_t         state_q, state_d;
  logic [WORD_W-1:0] held_q, held_d;
  logic              live_s, access_s, advance_s, sc_fail_s;
  logic [WORD_W-1:0] result_s;

  assign live_s    = (state_q != HELD);
  assign advance_s = ~pipe_stall;
  assign access_s  = memREN_in | (memWEN_in & ~sc_fail_s);

`ifdef LLSC_EN
  link_reg #(.WORD_W(WORD_W)) u_link (
    .CLK      (CLK),
    .nRST     (nRST),
    .ll_hit   (LL_in & memREN_in & bus.dhit & live_s),
    .sc_issue (SC_in & memWEN_in & live_s),
    .SC_in    (SC_in),
    .dhit     (bus.dhit),
    .addr_in  (addr_in),
    .ccinv    (bus.ccinv),
    .ccaddr   (bus.ccaddr),
    .sc_fail  (sc_fail_s)
  );
`else
  logic unused_s;
  assign unused_s  = ^{LL_in, bus.ccinv, bus.ccaddr};
  assign sc_fail_s = 1'b0;
`endif

  // Word the instruction produces this cycle: SC status, load data, or zero
  always_comb begin
    if (SC_in) begin
      result_s = {{(WORD_W-1){1'b0}}, ~sc_fail_s};
    end else if (memREN_in) begin
      result_s = bus.dload;
    end else begin
      result_s = '0;
    end
  end

  // Cache requests, stall and MEM/WB-facing outputs; HELD replays the latched word
  always_comb begin
    bus.dmemREN   = memREN_in & live_s;
    bus.dmemWEN   = memWEN_in & ~sc_fail_s & live_s;
    bus.dmemaddr  = addr_in;
    bus.dmemstore = store_in;
    mem_stall     = access_s & ~bus.dhit & live_s;
    regWEN_out    = regWEN_in & ~mem_stall;
    dmemload_out  = live_s ? result_s : held_q;
  end

  // FSM next state and capture of the result when the pipe is frozen at completion
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    case (state_q)
      IDLE: begin
        if (access_s & bus.dhit & ~advance_s) begin
          state_d = HELD;
          held_d  = result_s;
        end else if (access_s & ~bus.dhit) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // An SC losing its link mid-wait drops the access; do not wait for it
        if (~access_s) begin
          state_d = IDLE;
        end else if (bus.dhit & advance_s) begin
          state_d = IDLE;
        end else if (bus.dhit) begin
          state_d = HELD;
          held_d  = result_s;
        end else begin
          state_d = WAIT;
        end
      end
      HELD: begin
        if (advance_s) begin
          state_d = IDLE;
        end else begin
          state_d = HELD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and held-word flops
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage. LL/SC expectations follow the
// LLSC_EN build option.
module tb_mem_stage;
  import cpu_types_pkg::*;

  logic        CLK, nRST;
  logic        memREN_in, memWEN_in, LL_in, SC_in, regWEN_in, pipe_stall;
  logic [31:0] addr_in, store_in;
  logic        mem_stall, regWEN_out;
  logic [31:0] dmemload_out;
  int          checks, errors;

  mem_stage_if #(.WORD_W(32)) bus ();

  mem_stage #(.WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .memREN_in(memREN_in), .memWEN_in(memWEN_in), .LL_in(LL_in), .SC_in(SC_in),
    .addr_in(addr_in), .store_in(store_in), .regWEN_in(regWEN_in),
    .pipe_stall(pipe_stall), .bus(bus),
    .mem_stall(mem_stall), .dmemload_out(dmemload_out), .regWEN_out(regWEN_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ren, input logic wen, input logic ll, input logic sc,
                       input logic [31:0] a, input logic [31:0] st,
                       input logic hit, input logic [31:0] ld);
    memREN_in = ren; memWEN_in = wen; LL_in = ll; SC_in = sc;
    addr_in = a; store_in = st; bus.dhit = hit; bus.dload = ld;
    regWEN_in = ren; pipe_stall = 1'b0; bus.ccinv = 1'b0; bus.ccaddr = 32'h0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2;
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dut.state_q, IDLE); end
    checks++; if (bus.dmemREN !== 1'b0 || bus.dmemWEN !== 1'b0) begin errors++; $display("FAIL reset_req got %b%b exp 00", bus.dmemREN, bus.dmemWEN); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", mem_stall); end
    checks++; if (dmemload_out !== 32'h0) begin errors++; $display("FAIL reset_load got %h exp 0", dmemload_out); end
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_load_hit();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'hDEADBEEF);
    #2;
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL hit_stall got %b exp 0", mem_stall); end
    checks++; if (dmemload_out !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_load got %h exp deadbeef", dmemload_out); end
    checks++; if (bus.dmemREN !== 1'b1 || bus.dmemaddr !== 32'h40) begin errors++; $display("FAIL hit_req got %b/%h exp 1/40", bus.dmemREN, bus.dmemaddr); end
    checks++; if (regWEN_out !== 1'b1) begin errors++; $display("FAIL hit_regwen got %b exp 1", regWEN_out); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h11112222);
    #2;
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL hit_state got %0d exp %0d", dut.state_q, IDLE); end
    checks++; if (dmemload_out !== 32'h0 || mem_stall !== 1'b0) begin errors++; $display("FAIL noaccess_out got %h/%b exp 0/0", dmemload_out, mem_stall); end
    tick();
  endtask

  task automatic test_store_miss();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'hCAFE0001, 1'b0, 32'h0);
    regWEN_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (bus.dmemWEN !== 1'b1 || bus.dmemstore !== 32'hCAFE0001) begin errors++; $display("FAIL miss_wen[%0d] got %b/%h exp 1/cafe0001", i, bus.dmemWEN, bus.dmemstore); end
      checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL miss_stall[%0d] got %b exp 1", i, mem_stall); end
      checks++; if (regWEN_out !== 1'b0) begin errors++; $display("FAIL miss_regwen[%0d] got %b exp 0", i, regWEN_out); end
      tick();
      if (i == 0) begin
        checks++; if (dut.state_q !== WAIT) begin errors++; $display("FAIL miss_state got %0d exp %0d", dut.state_q, WAIT); end
      end
      #0;
    end
    bus.dhit = 1'b1;
    #2;
    checks++; if (mem_stall !== 1'b0 || regWEN_out !== 1'b1) begin errors++; $display("FAIL miss_done got %b/%b exp 0/1", mem_stall, regWEN_out); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2;
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL miss_end_state got %0d exp %0d", dut.state_q, IDLE); end
    tick();
  endtask

  task automatic test_load_held();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 1'b1, 32'h12345678);
    pipe_stall = 1'b1;
    #2;
    checks++; if (mem_stall !== 1'b0 || dmemload_out !== 32'h12345678) begin errors++; $display("FAIL held_first got %b/%h exp 0/12345678", mem_stall, dmemload_out); end
    tick();
    bus.dhit = 1'b0; bus.dload = 32'hBAD0BAD0;
    #2;
    checks++; if (dut.state_q !== HELD) begin errors++; $display("FAIL held_state got %0d exp %0d", dut.state_q, HELD); end
    checks++; if (bus.dmemREN !== 1'b0) begin errors++; $display("FAIL held_ren got %b exp 0", bus.dmemREN); end
    checks++; if (dmemload_out !== 32'h12345678 || mem_stall !== 1'b0) begin errors++; $display("FAIL held_load got %h/%b exp 12345678/0", dmemload_out, mem_stall); end
    tick();
    pipe_stall = 1'b0; bus.dhit = 1'b1; bus.dload = 32'h0F0F0F0F;
    #2;
    checks++; if (dmemload_out !== 32'h12345678) begin errors++; $display("FAIL held_release got %h exp 12345678", dmemload_out); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2;
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL held_end_state got %0d exp %0d", dut.state_q, IDLE); end
    tick();
  endtask

  // LL to addr with hit this cycle, optional same-cycle snoop
  task automatic do_ll(input logic [31:0] a, input logic inv, input logic [31:0] ia);
    drive(1'b1, 1'b0, 1'b1, 1'b0, a, 32'h0, 1'b1, 32'h00000055);
    bus.ccinv = inv; bus.ccaddr = ia;
    tick();
  endtask

  // SC to addr with dhit high; checks write request and status word
  task automatic do_sc(input string nm, input logic [31:0] a, input logic exp_ok);
    drive(1'b0, 1'b1, 1'b0, 1'b1, a, 32'hA5A5A5A5, 1'b1, 32'h0);
    #2;
    checks++; if (bus.dmemWEN !== exp_ok) begin errors++; $display("FAIL %s_wen got %b exp %b", nm, bus.dmemWEN, exp_ok); end
    checks++; if (dmemload_out !== {31'h0, exp_ok} || mem_stall !== 1'b0) begin errors++; $display("FAIL %s_result got %h/%b exp %h/0", nm, dmemload_out, mem_stall, {31'h0, exp_ok}); end
    tick();
  endtask

  task automatic test_llsc();
    logic ok_cond;
`ifdef LLSC_EN
    ok_cond = 1'b0;
`else
    ok_cond = 1'b1;
`endif
    do_ll(32'h100, 1'b0, 32'h0);
    do_sc("sc_word_diff", 32'h104, ok_cond);
    do_sc("sc_after_fail", 32'h100, ok_cond);
    do_ll(32'h100, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    bus.ccinv = 1'b1; bus.ccaddr = 32'h102;
    tick();
    do_sc("sc_snooped", 32'h100, ok_cond);
    do_ll(32'h100, 1'b0, 32'h0);
    do_sc("sc_ok", 32'h103, 1'b1);
    do_sc("sc_second", 32'h100, ok_cond);
    do_ll(32'h200, 1'b1, 32'h203);
    do_sc("sc_inv_same_cycle", 32'h200, ok_cond);
    do_ll(32'h300, 1'b1, 32'h400);
    do_sc("sc_other_inv", 32'h300, 1'b1);
  endtask

  task automatic test_reset_mid_wait();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h60, 32'h0, 1'b0, 32'h0);
    tick();
    checks++; if (dut.state_q !== WAIT) begin errors++; $display("FAIL rst_wait_pre got %0d exp %0d", dut.state_q, WAIT); end
    nRST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h77777777);
    #1;
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_wait_state got %0d exp %0d", dut.state_q, IDLE); end
    nRST = 1'b1;
    #1;
    checks++; if (bus.dmemREN !== 1'b0 || mem_stall !== 1'b0 || dmemload_out !== 32'h0) begin errors++; $display("FAIL rst_wait_out got %b/%b/%h exp 0/0/0", bus.dmemREN, mem_stall, dmemload_out); end
    tick();
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_wait_noretry got %0d exp %0d", dut.state_q, IDLE); end
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_load_hit();
    test_store_miss();
    test_load_held();
    test_llsc();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
